// File: rtl/digit_sign_encoder_if.sv
// Digit-pair input stream and word-sign result bus for digit_sign_encoder.
// Latency: n/a (wiring only); master = producer/consumer side, slave = encoder side.
// Backpressure: in_valid/in_ready on the digit stream, out_valid/out_ready on the result.
interface digit_sign_encoder_if #(
  parameter int DIGIT_W    = 8,
  parameter int MAX_DIGITS = 16
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic               in_valid;
  logic               in_ready;
  logic [DIGIT_W-1:0] a_digit;
  logic [DIGIT_W-1:0] b_digit;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_sign;
  logic [CNT_W-1:0]   out_count;
  logic               out_err;
  logic               dig_valid;
  logic [1:0]         dig_sign;

  modport master (
    output in_valid, a_digit, b_digit, in_last, out_ready,
    input  in_ready, out_valid, out_sign, out_count, out_err, dig_valid, dig_sign
  );

  modport slave (
    input  in_valid, a_digit, b_digit, in_last, out_ready,
    output in_ready, out_valid, out_sign, out_count, out_err, dig_valid, dig_sign
  );
endinterface

// File: rtl/digit_sign_encoder.sv
// Serial mixed-radix magnitude compare: folds per-digit codes (00 lt, 01 eq, 10 gt) into a word sign.
// Latency: out_valid one cycle after the last beat is accepted; dig_* one cycle after each beat.
// Backpressure: in_ready low while a result is held; result held until out_ready. Option: SIGN_STREAM_EN.
module digit_sign_encoder #(
  parameter int DIGIT_W    = 8,
  parameter int MAX_DIGITS = 16,
  parameter int MSD_FIRST  = 0
) (
  input logic                clk,
  input logic                reset,
  digit_sign_encoder_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] SIGN_LT = 2'b00;
  localparam logic [1:0] SIGN_EQ = 2'b01;
  localparam logic [1:0] SIGN_GT = 2'b10;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]         state;
  logic [1:0]         acc;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         out_sign_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               out_err_q;

  logic [DIGIT_W-1:0] a_d;
  logic [DIGIT_W-1:0] b_d;
  logic [1:0]         code;
  logic [1:0]         acc_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;
  logic               hit_max;
  logic               word_end;

  assign a_d = bus.a_digit;
  assign b_d = bus.b_digit;

  // in_ready depends only on state so it can never combinationally loop through in_valid
  assign bus.in_ready  = (state == ST_ACCUM);
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.out_sign  = out_sign_q;
  assign bus.out_count = out_count_q;
  assign bus.out_err   = out_err_q;

  assign accept   = bus.in_valid & bus.in_ready;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign hit_max  = (cnt_inc == CNT_W'(MAX_DIGITS));
  assign word_end = accept & (bus.in_last | hit_max);

  // Unsigned full-width digit compare into the 2-bit sign code
  always_comb begin
    code = SIGN_EQ;
    if (a_d > b_d)      code = SIGN_GT;
    else if (a_d < b_d) code = SIGN_LT;
  end

  // Fold rule: the most significant non-equal digit decides the word sign
  always_comb begin
    acc_next = acc;
    if (MSD_FIRST != 0) begin
      // MSD arrives first: the first non-equal digit sticks
      if (acc == SIGN_EQ) acc_next = code;
    end else begin
      // LSD arrives first: each later non-equal digit overrides
      if (code != SIGN_EQ) acc_next = code;
    end
  end

  // Word FSM: accumulate beats, then hold the registered result until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_ACCUM;
      acc         <= SIGN_EQ;
      cnt         <= '0;
      out_sign_q  <= SIGN_EQ;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_inc;
            if (word_end) begin
              state       <= ST_HOLD;
              out_sign_q  <= acc_next;
              out_count_q <= cnt_inc;
              // in_last on the final allowed beat is a normal end, not an overrun
              out_err_q   <= ~bus.in_last;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state <= ST_ACCUM;
            acc   <= SIGN_EQ;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

`ifdef SIGN_STREAM_EN
  logic       dig_valid_q;
  logic [1:0] dig_sign_q;

  // Raw per-digit code stream, one register stage behind acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_valid_q <= 1'b0;
      dig_sign_q  <= SIGN_EQ;
    end else begin
      dig_valid_q <= accept;
      if (accept) dig_sign_q <= code;
    end
  end

  assign bus.dig_valid = dig_valid_q;
  assign bus.dig_sign  = dig_sign_q;
`else
  assign bus.dig_valid = 1'b0;
  assign bus.dig_sign  = SIGN_EQ;
`endif

endmodule

// File: tb/tb_digit_sign_encoder.sv
// Directed bench: LSD-first and MSD-first encoders driven in lockstep with identical beats.
// Inputs are driven and outputs sampled on the falling edge, half a cycle after the active edge.
module tb_digit_sign_encoder;
  localparam int DIGIT_W    = 8;
  localparam int MAX_DIGITS = 16;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   n_beats;
  int   dig_pulses;

  digit_sign_encoder_if #(.DIGIT_W(DIGIT_W), .MAX_DIGITS(MAX_DIGITS)) if_lsd ();
  digit_sign_encoder_if #(.DIGIT_W(DIGIT_W), .MAX_DIGITS(MAX_DIGITS)) if_msd ();

  digit_sign_encoder #(.DIGIT_W(DIGIT_W), .MAX_DIGITS(MAX_DIGITS), .MSD_FIRST(0)) u_lsd (
    .clk(clk), .reset(reset), .bus(if_lsd)
  );
  digit_sign_encoder #(.DIGIT_W(DIGIT_W), .MAX_DIGITS(MAX_DIGITS), .MSD_FIRST(1)) u_msd (
    .clk(clk), .reset(reset), .bus(if_msd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && if_lsd.dig_valid) dig_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [7:0] a, input logic [7:0] b, input logic last);
    if_lsd.in_valid = vld; if_lsd.a_digit = a; if_lsd.b_digit = b; if_lsd.in_last = last;
    if_msd.in_valid = vld; if_msd.a_digit = a; if_msd.b_digit = b; if_msd.in_last = last;
  endtask

  task automatic set_ready(input logic r);
    if_lsd.out_ready = r;
    if_msd.out_ready = r;
  endtask

  // One accepted beat: drive at a falling edge, return at the next falling edge
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    drive(1'b1, a, b, last);
    n_beats++;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
  endtask

  task automatic check_dig(input string tag, input logic [1:0] exp_code);
`ifdef SIGN_STREAM_EN
    check({tag, ".dv"}, {31'd0, if_lsd.dig_valid}, 32'd1);
    check({tag, ".ds"}, {30'd0, if_lsd.dig_sign}, {30'd0, exp_code});
    check({tag, ".ds_msd"}, {30'd0, if_msd.dig_sign}, {30'd0, exp_code});
`else
    check({tag, ".dv"}, {31'd0, if_lsd.dig_valid}, 32'd0);
    check({tag, ".ds"}, {30'd0, if_lsd.dig_sign}, 32'h1);
`endif
  endtask

  // Result check at the falling edge following the last beat
  task automatic check_word(input string tag, input logic [1:0] s_lsd, input logic [1:0] s_msd,
                            input int count, input logic err);
    check({tag, ".ov"},   {31'd0, if_lsd.out_valid}, 32'd1);
    check({tag, ".ir"},   {31'd0, if_lsd.in_ready},  32'd0);
    check({tag, ".sl"},   {30'd0, if_lsd.out_sign},  {30'd0, s_lsd});
    check({tag, ".sm"},   {30'd0, if_msd.out_sign},  {30'd0, s_msd});
    check({tag, ".cnt"},  {27'd0, if_lsd.out_count}, count);
    check({tag, ".err"},  {31'd0, if_lsd.out_err},   {31'd0, err});
    check({tag, ".ovm"},  {31'd0, if_msd.out_valid}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".ov"},  {31'd0, if_lsd.out_valid}, 32'd0);
    check({tag, ".ir"},  {31'd0, if_lsd.in_ready},  32'd1);
    check({tag, ".s"},   {30'd0, if_lsd.out_sign},  32'h1);
    check({tag, ".cnt"}, {27'd0, if_lsd.out_count}, 32'd0);
    check({tag, ".err"}, {31'd0, if_lsd.out_err},   32'd0);
    check({tag, ".dv"},  {31'd0, if_lsd.dig_valid}, 32'd0);
    check({tag, ".ds"},  {30'd0, if_lsd.dig_sign},  32'h1);
    check({tag, ".irm"}, {31'd0, if_msd.in_ready},  32'd1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_beats = 0; dig_pulses = 0;
    reset = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("post_rst");

    // LSD-first {3,5,7} vs {3,9,2}: codes 01,00,10 -> LSD 10, MSD-rule 00
    beat(8'd3, 8'd3, 1'b0); check_dig("t1b0", 2'b01);
    beat(8'd5, 8'd9, 1'b0); check_dig("t1b1", 2'b00);
    check("t1.ov_mid", {31'd0, if_lsd.out_valid}, 32'd0);
    beat(8'd7, 8'd2, 1'b1); check_dig("t1b2", 2'b10);
    check_word("t1", 2'b10, 2'b00, 3, 1'b0);
    idle();
    check("t1.ov_one", {31'd0, if_lsd.out_valid}, 32'd0);
    check("t1.ir_back", {31'd0, if_lsd.in_ready}, 32'd1);
`ifdef SIGN_STREAM_EN
    check("t1.dv_gap", {31'd0, if_lsd.dig_valid}, 32'd0);
`endif

    // {4,1} vs {2,9}: codes 10,00 -> MSD-first 10, LSD-first 00
    beat(8'd4, 8'd2, 1'b0);
    beat(8'd1, 8'd9, 1'b1);
    check_word("t2", 2'b00, 2'b10, 2, 1'b0);
    idle();

    // Four equal 0xFF pairs -> 01, then single {0,1} -> 00
    for (int i = 0; i < 4; i++) beat(8'hFF, 8'hFF, (i == 3));
    check_word("t3eq", 2'b01, 2'b01, 4, 1'b0);
    idle();
    beat(8'd0, 8'd1, 1'b1);
    check_word("t3one", 2'b00, 2'b00, 1, 1'b0);
    idle();

    // 16 beats without in_last: a=i, b=15-i; first code 00, last code 10
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4.ir%0d", i), {31'd0, if_lsd.in_ready}, 32'd1);
      beat(8'(i), 8'(15 - i), 1'b0);
    end
    check_word("t4max", 2'b10, 2'b00, 16, 1'b1);
    idle();
    // Next word must start from 01 again
    beat(8'd5, 8'd5, 1'b1);
    check_word("t4next", 2'b01, 2'b01, 1, 1'b0);
    idle();

    // in_last on the 16th beat is a normal end
    beat(8'd1, 8'd0, 1'b0);
    for (int i = 1; i < 16; i++) beat(8'd7, 8'd7, (i == 15));
    check_word("t4last", 2'b10, 2'b10, 16, 1'b0);
    idle();

    // {2v1,1v1,0v5}: stream 10,01,00; LSD word 00, MSD word 10
    beat(8'd2, 8'd1, 1'b0); check_dig("t6b0", 2'b10);
    beat(8'd1, 8'd1, 1'b0); check_dig("t6b1", 2'b01);
    beat(8'd0, 8'd5, 1'b1); check_dig("t6b2", 2'b00);
    check_word("t6", 2'b00, 2'b10, 3, 1'b0);
    idle();

    // Backpressure: result held for 5 cycles, beats offered in HOLD are ignored
    set_ready(1'b0);
    beat(8'd9, 8'd3, 1'b1);
    drive(1'b1, 8'd0, 8'd200, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check_word($sformatf("t5h%0d", c), 2'b10, 2'b10, 1, 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    set_ready(1'b1);
    @(negedge clk);
    check("t5.ov_rel", {31'd0, if_lsd.out_valid}, 32'd0);
    check("t5.cnt_kept", {27'd0, if_lsd.out_count}, 32'd1);

    // Reset during HOLD on the 3rd cycle aborts the word
    set_ready(1'b0);
    beat(8'd0, 8'd1, 1'b1);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    check_word("t5r0", 2'b00, 2'b00, 1, 1'b0);
    @(negedge clk);
    check_word("t5r1", 2'b00, 2'b00, 1, 1'b0);
    @(negedge clk);
    check_word("t5r2", 2'b00, 2'b00, 1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("t5rst");
    reset = 1'b0;
    set_ready(1'b1);
    @(negedge clk);
    check_reset_state("t5after");

    // Every accepted beat gives exactly one dig_valid pulse when streaming is built in
    repeat (2) @(negedge clk);
`ifdef SIGN_STREAM_EN
    check("dig_pulses", dig_pulses, n_beats);
`else
    check("dig_pulses", dig_pulses, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/digit_sign_encoder.md
# digit_sign_encoder

Serial magnitude comparator that produces 2-bit sign codes for the sign-flag chain. It accepts two mixed-radix operands one digit pair per beat and encodes each pair as less/equal/greater. It folds the codes into one word-level sign and delivers it on a valid/ready output. The block is the source end of the sign-code convention used by the compare logic in the TPU datapath: 01 equal, 10 greater, 00 less, 11 never generated.

## Interface
- DIGIT_W, 8: width of one mixed-radix digit (unsigned).
- MAX_DIGITS, 16: maximum digit pairs per word; forced termination at this count.
- MSD_FIRST, 0: 0 = digits arrive least significant first; 1 = most significant first.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  digit pair present.
- in_ready  out  1  block accepts a digit pair this cycle.
- a_digit  in  DIGIT_W  operand A digit.
- b_digit  in  DIGIT_W  operand B digit.
- in_last  in  1  final digit pair of the word.
- out_valid  out  1  word result held.
- out_ready  in  1  consumer takes result.
- out_sign  out  2  word sign code, A relative to B.
- out_count  out  $clog2(MAX_DIGITS+1)  digit pairs consumed for this word.
- out_err  out  1  word terminated by MAX_DIGITS without in_last.
- dig_valid  out  1  per-digit code strobe (see Configuration).
- dig_sign  out  2  per-digit sign code (see Configuration).

## Operation
- Per-digit encode: a_digit > b_digit gives 10; equal gives 01; less gives 00. The comparison is unsigned at full DIGIT_W.
- Accumulator acc[1:0] is initialised to 01 at the start of every word.
- MSD_FIRST=0: acc <= (code == 01) ? acc : code. The last non-equal digit is the most significant one, and it wins.
- MSD_FIRST=1: acc <= (acc == 01) ? code : acc. The first non-equal digit wins.
- FSM states:
  - ACCUM: in_ready=1. On each accepted beat (in_valid & in_ready), update acc and increment cnt.
  - ACCUM -> HOLD: when the accepted beat has in_last=1, or cnt+1 == MAX_DIGITS. Load out_sign from the updated acc and out_count from cnt+1. Set out_err=1 if in_last=0.
  - HOLD: in_ready=0 and out_valid=1. Outputs stay stable until out_ready=1.
  - HOLD -> ACCUM: on out_ready. Clear acc to 01 and cnt to 0.
- All-equal word yields 01. A single-digit word yields that digit's code.
- in_last together with the MAX_DIGITS-th beat: normal termination, out_err=0.
- Reset in any state aborts the word:
  - state=ACCUM, acc=01, cnt=0.
  - out_valid=0, out_sign=01, out_count=0, out_err=0, dig_valid=0, dig_sign=01.
- in_valid low in ACCUM: no state change (bubbles allowed).

## Timing
- in_ready is combinational from the state only; it never depends on in_valid.
- Word latency: out_valid rises on the cycle after the last beat is accepted.
- Throughput: one digit per cycle within a word. There is one bubble cycle per word minimum (the HOLD cycle), even with out_ready tied high.
- out_sign, out_count and out_err are registered and change only on ACCUM->HOLD transitions and on reset.
- dig_valid/dig_sign are registered, one cycle after the accepted beat. This matches the 1-stage latency of the downstream latched compare chain.

## Configuration
- SIGN_STREAM_EN defined: dig_valid pulses for one cycle per accepted beat, and dig_sign carries that beat's raw code. This lets the code stream drive an external latched compare chain directly.
- SIGN_STREAM_EN undefined: dig_valid is tied 0 and dig_sign tied 01; the per-digit register is removed. Word-level behaviour is identical in both builds.

## Test plan
- LSD-first, A digits {3,5,7}, B digits {3,9,2}, last on third, out_ready=1 -> out_sign=10, out_count=3, out_err=0, out_valid for exactly one cycle, one cycle after the third beat.
- MSD_FIRST=1, A {4,1}, B {2,9} -> out_sign=10. The same data sent with MSD_FIRST=0 -> out_sign=00.
- Four equal pairs {0xFF,0xFF} -> out_sign=01. Then a single pair {0,1} -> out_sign=00, out_count=1.
- 16 beats with no in_last, MAX_DIGITS=16 -> HOLD after the 16th beat with out_err=1, out_count=16. Next word starts with acc=01.
- out_ready held low for 5 cycles in HOLD -> in_ready=0 and outputs stable throughout. Assert reset on the 3rd cycle -> next cycle out_valid=0, out_sign=01, in_ready=1.
- SIGN_STREAM_EN build, beats {2v1,1v1,0v5} -> dig_sign sequence 10,01,00, each one cycle after acceptance. Non-EN build -> dig_valid never 1.
